// File: rtl/rom_programmer.sv
// Bit-serial programmer for 4x256 bipolar fuse PROMs: pulse, recover, verify, bounded retries.
// Define ROM_PROGRAMMER_PULSE_COUNT_EN to add a saturating pulse_count output.
module rom_programmer #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES   = 20,
  parameter int unsigned RECOVER_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line_out,
  output logic                     data_line_oe,
  output logic                     program_pulse,
  output logic                     chip_select_n,
  output logic [3:0]               operation,
  output logic                     done,
`ifdef ROM_PROGRAMMER_PULSE_COUNT_EN
  output logic [15:0]              pulse_count,
`endif
  output logic [1:0]               error
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0] SetupLast   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PulseLast   = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] RecoverLast = 16'(RECOVER_CYCLES - 1);
  localparam logic [7:0]  MaxRetries  = 8'(MAX_RETRIES);

  typedef enum logic [3:0] {
    StIdle        = 4'd0,
    StSetup       = 4'd1,
    StRead        = 4'd2,
    StCheck       = 4'd3,
    StSelectBit   = 4'd4,
    StPulse       = 4'd5,
    StRecover     = 4'd6,
    StVerifySetup = 4'd7,
    StDone        = 4'd8
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [7:0]               retry_q, retry_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    target_q, target_d;
  logic [DATA_WIDTH-1:0]    current_q, current_d;
  logic [IdxW-1:0]          bit_q, bit_d;
  logic [1:0]               error_q, error_d;
  logic [DATA_WIDTH-1:0]    need;
  logic [IdxW-1:0]          sel_idx;

  // Lowest bit still to be blown.
  always_comb begin
    need    = target_q & ~current_q;
    sel_idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (need[i]) sel_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    addr_d    = addr_q;
    target_d  = target_q;
    current_d = current_q;
    bit_d     = bit_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (wr_valid) begin
          addr_d   = wr_address;
          target_d = wr_data;
          error_d  = 2'd0;
          cnt_d    = '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRead: begin
        current_d = data_line_in;
        state_d   = (|(target_q & ~data_line_in)) ? StSelectBit : StCheck;
      end
      StCheck: begin
        if (|(current_q & ~target_q)) error_d = 2'd1;
        state_d = StDone;
      end
      StSelectBit: begin
        bit_d   = sel_idx;
        retry_d = 8'd1;  // cleared here, then counted for the pulse being entered
        cnt_d   = '0;
        state_d = StPulse;
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          cnt_d   = '0;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRecover: begin
        if (cnt_q == RecoverLast) begin
          cnt_d   = '0;
          state_d = StVerifySetup;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StVerifySetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d     = '0;
          current_d = data_line_in;
          if (data_line_in[bit_q]) begin
            state_d = StRead;
          end else if (retry_q < MaxRetries) begin
            retry_d = retry_q + 8'd1;
            state_d = StPulse;
          end else begin
            error_d = 2'd2;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      retry_q   <= '0;
      addr_q    <= '0;
      target_q  <= '0;
      current_q <= '0;
      bit_q     <= '0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      addr_q    <= addr_d;
      target_q  <= target_d;
      current_q <= current_d;
      bit_q     <= bit_d;
      error_q   <= error_d;
    end
  end

  // Outputs decode straight from state so an async reset drops the pulse immediately.
  always_comb begin
    wr_ready      = (state_q == StIdle);
    chip_select_n = (state_q == StIdle) || (state_q == StDone);
    program_pulse = (state_q == StPulse);
    data_line_oe  = (state_q == StPulse);
    data_line_out = (state_q == StPulse) ? (DATA_WIDTH'(1) << bit_q) : '0;
    done          = (state_q == StDone);
    operation     = state_q;
    address_line  = addr_q;
    error         = error_q;
  end

`ifdef ROM_PROGRAMMER_PULSE_COUNT_EN
  logic        pulse_entry;
  logic [15:0] pulse_count_q;

  assign pulse_entry = (state_d == StPulse) && (state_q != StPulse);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_count_q <= '0;
    end else if (pulse_entry && (pulse_count_q != 16'hFFFF)) begin
      pulse_count_q <= pulse_count_q + 16'd1;
    end
  end

  assign pulse_count = pulse_count_q;
`endif

endmodule
